// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - register window and trap handshake bundle for irq_controller
interface irq_controller_if #(
    parameter int N_IRQ   = 8,
    parameter int CAUSE_W = 32
);
    logic               reg_wr;
    logic [1:0]         reg_addr;
    logic [N_IRQ-1:0]   reg_wdata;
    logic [N_IRQ-1:0]   reg_rdata;
    logic               irq_req;
    logic [CAUSE_W-1:0] irq_cause;
    logic               irq_ack;
    logic               irq_done;
    logic               busy;

    // core / CSR side
    modport master (
        output reg_wr, reg_addr, reg_wdata, irq_ack, irq_done,
        input  reg_rdata, irq_req, irq_cause, busy
    );

    // controller side
    modport slave (
        input  reg_wr, reg_addr, reg_wdata, irq_ack, irq_done,
        output reg_rdata, irq_req, irq_cause, busy
    );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - fixed-priority multi-source interrupt controller with req/ack/done handshake
module irq_controller #(
    parameter int N_IRQ      = 8,
    parameter int CAUSE_W    = 32,
    parameter int CAUSE_BASE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_src,
    irq_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    logic [N_IRQ-1:0]   enable;
    logic [N_IRQ-1:0]   mode;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   src_q;
    logic [4:0]         win_id;
    logic               req_q;
    logic               busy_q;
    logic [CAUSE_W-1:0] cause_q;

    logic [N_IRQ-1:0]   elig;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   clr;
    logic [N_IRQ-1:0]   win_mask;
    logic [N_IRQ-1:0]   ack_mask;
    logic [N_IRQ-1:0]   pending_nxt;
    logic [4:0]         win_nxt;
    logic [CAUSE_W-1:0] cause_nxt;
    logic               any_elig;
    logic               win_elig;
    logic               ack_take;
    logic               w1c;

    assign elig     = pending & enable;
    assign any_elig = |elig;
    assign rise     = irq_src & ~src_q;
    assign win_mask = N_IRQ'(1) << win_id;
    assign win_elig = |(elig & win_mask);
    assign ack_take = (state == REQ) && bus.irq_ack;
    assign ack_mask = ack_take ? win_mask : '0;
    assign w1c      = bus.reg_wr && (bus.reg_addr == 2'd2);
    assign clr      = (w1c ? bus.reg_wdata : '0) | ack_mask;

    // level sources follow the pin; edge sources latch a rise, which beats any same-cycle clear
    assign pending_nxt = (~mode & irq_src) | (mode & (rise | (pending & ~clr)));

    // lowest eligible index wins: scan downward so the last hit is the lowest
    always_comb begin
        win_nxt = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_nxt = 5'(i);
            end
        end
    end

    // mcause for the candidate winner, MSB flags it as an interrupt
    always_comb begin
        cause_nxt = CAUSE_W'(CAUSE_BASE) + CAUSE_W'(win_nxt);
        cause_nxt[CAUSE_W-1] = 1'b1;
    end

    // source sampling, pending tracking and the software-writable registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable  <= '0;
            mode    <= '0;
            pending <= '0;
            src_q   <= '0;
        end else begin
            src_q   <= irq_src;
            pending <= pending_nxt;
            if (bus.reg_wr && bus.reg_addr == 2'd0) begin
                enable <= bus.reg_wdata;
            end
            if (bus.reg_wr && bus.reg_addr == 2'd1) begin
                mode <= bus.reg_wdata;
            end
        end
    end

    // request/service sequencer; the latched winner is not re-arbitrated while requesting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            win_id  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        win_id  <= win_nxt;
                        cause_q <= cause_nxt;
                        req_q   <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        req_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SERVICE;
                    end else if (!win_elig) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (bus.irq_done) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    req_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // combinational register read
    always_comb begin
        case (bus.reg_addr)
            2'd0:    bus.reg_rdata = enable;
            2'd1:    bus.reg_rdata = mode;
            2'd2:    bus.reg_rdata = pending;
            default: bus.reg_rdata = N_IRQ'({state, win_id});
        endcase
    end

    assign bus.irq_req   = req_q;
    assign bus.busy      = busy_q;
    assign bus.irq_cause = cause_q;
endmodule
